uart_rx: RTL and testbench

- Serial receiver: the downstream partner of the team's UART transmitter. It consumes the `tx_data` line of a link (8N1 framing, LSB first, 115200 baud at 50 MHz) and delivers one parallel byte per frame.
- Samples each bit at its mid-point using a baud counter of the same length as the transmitter's.
- Rejects false starts and flags framing errors.
- Output is a byte plus a one-cycle strobe, which feeds directly into a loopback or into a command parser.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_sync.sv | 30 +++
 rtl/uart_rx.sv | 110 +++++++++++
 tb/tb_uart_rx.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state encoding.
// The transmitter takes its counter end value from here too, so both ends keep the same bit timing.
package uart_pkg;

  localparam int CLK_FREQ     = 50_000_000;
  localparam int BAUD         = 115200;
  localparam int BAUD_CNT_END = CLK_FREQ / BAUD - 1;
  localparam int BAUD_CNT_MID = (BAUD_CNT_END + 1) / 2 - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Brings an asynchronous input into the clk domain through two flops.
// A third flop detects high-to-low transitions. All flops reset high so that an idle-high line shows no edge.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_s3 <= 1'b1;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_sync = r_s2;
  assign o_fall = r_s3 & ~r_s2;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: samples each bit once at its mid-point and delivers a byte with a one-cycle strobe.
//   state | meaning
//   IDLE  | line idle, waiting for a falling edge
//   START | checking the start bit at mid-point, rejects glitches
//   DATA  | shifting in 8 data bits, LSB first
//   STOP  | sampling the stop bit, strobes at mid-point and returns to IDLE
module uart_rx #(
  parameter int CLK_FREQ = uart_pkg::CLK_FREQ,
  parameter int BAUD     = uart_pkg::BAUD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_data,
  output logic [7:0] po_data,
  output logic       po_flag,
  output logic       frame_err
);

  import uart_pkg::*;

  localparam int LP_CNT_END = CLK_FREQ / BAUD - 1;
  localparam int LP_CNT_MID = (LP_CNT_END + 1) / 2 - 1;
  localparam int LP_CNT_W   = $clog2(LP_CNT_END + 1);

  logic                w_rx_s2;
  logic                w_start_edge;
  logic                w_cnt_end;
  logic                w_cnt_mid;

  rx_state_e           r_state;
  logic [LP_CNT_W-1:0] r_baud_cnt;
  logic [2:0]          r_bit_cnt;
  logic [7:0]          r_shift;
  logic [7:0]          r_po_data;
  logic                r_po_flag;
  logic                r_frame_err;

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (rx_data),
    .o_sync  (w_rx_s2),
    .o_fall  (w_start_edge)
  );

  assign w_cnt_end = (r_baud_cnt == LP_CNT_W'(LP_CNT_END));
  assign w_cnt_mid = (r_baud_cnt == LP_CNT_W'(LP_CNT_MID));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_baud_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_po_data   <= '0;
      r_po_flag   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_po_flag   <= 1'b0;
      r_frame_err <= 1'b0;

      if (r_state == IDLE || w_cnt_end)
        r_baud_cnt <= '0;
      else
        r_baud_cnt <= r_baud_cnt + 1'b1;

      case (r_state)
        IDLE: begin
          r_bit_cnt <= '0;
          if (w_start_edge)
            r_state <= START;
        end
        START: begin
          if (w_cnt_mid && w_rx_s2)
            r_state <= IDLE;
          else if (w_cnt_end)
            r_state <= DATA;
        end
        DATA: begin
          if (w_cnt_mid)
            r_shift[r_bit_cnt] <= w_rx_s2;
          if (w_cnt_end) begin
            if (r_bit_cnt == 3'd7)
              r_state <= STOP;
            else
              r_bit_cnt <= r_bit_cnt + 3'd1;
          end
        end
        STOP: begin
          // Leave at the mid-point so a back-to-back start bit is never missed.
          if (w_cnt_mid) begin
            r_state <= IDLE;
            if (w_rx_s2) begin
              r_po_data <= r_shift;
              r_po_flag <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign po_data   = r_po_data;
  assign po_flag   = r_po_flag;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: scenario tasks plus randomized frames against a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int P = 434;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_data = 1'b1;
  logic [7:0] po_data;
  logic       po_flag;
  logic       frame_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_fall_cyc = 0;
  logic [7:0] exp_last = 8'h00;

  logic [7:0] flag_data[$];
  int         flag_cyc[$];
  int         err_cyc[$];
  int         viol_width = 0;
  int         viol_excl = 0;
  int         viol_stable = 0;
  logic       prev_flag = 1'b0;
  logic       prev_err = 1'b0;
  logic [7:0] prev_data = 8'h00;

  uart_rx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .po_data   (po_data),
    .po_flag   (po_flag),
    .frame_err (frame_err)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      if (po_flag) begin
        flag_data.push_back(po_data);
        flag_cyc.push_back(cyc);
      end
      if (frame_err) err_cyc.push_back(cyc);
      if (po_flag && frame_err) viol_excl++;
      if ((po_flag && prev_flag) || (frame_err && prev_err)) viol_width++;
      if (!po_flag && po_data !== prev_data) viol_stable++;
    end
    prev_flag = po_flag;
    prev_err  = frame_err;
    prev_data = po_data;
  end

  task automatic idle(input int n);
    rx_data = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input int per, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_data = bits[i];
      if (i == 0) last_fall_cyc = cyc;
      repeat (per) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if (po_data !== 8'h00 || po_flag !== 1'b0 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: data=%h flag=%b err=%b, want 00/0/0", po_data, po_flag, frame_err);
    end
    rst_n = 1'b1;
    idle(20);
    checks++;
    if (po_data !== 8'h00 || po_flag !== 1'b0 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: data=%h flag=%b err=%b, want 00/0/0", po_data, po_flag, frame_err);
    end
  endtask

  task automatic test_back_to_back;
    int fb, eb;
    fb = flag_data.size();
    eb = err_cyc.size();
    send_frame(8'h55, P, 1'b1);
    send_frame(8'hA5, P, 1'b1);
    idle(50);
    checks++;
    if (flag_data.size() != fb + 2 || err_cyc.size() != eb) begin
      failures++;
      $display("FAIL b2b_count: flags=%0d errs=%0d, want 2/0", flag_data.size() - fb, err_cyc.size() - eb);
    end else begin
      checks++;
      if (flag_data[fb] !== 8'h55 || flag_data[fb+1] !== 8'hA5) begin
        failures++;
        $display("FAIL b2b_data: got %h,%h want 55,A5", flag_data[fb], flag_data[fb+1]);
      end
      checks++;
      if (flag_cyc[fb+1] - flag_cyc[fb] != 10 * P) begin
        failures++;
        $display("FAIL b2b_spacing: got %0d want %0d", flag_cyc[fb+1] - flag_cyc[fb], 10 * P);
      end
      exp_last = 8'hA5;
    end
  endtask

  task automatic test_false_start;
    int fb, eb;
    fb = flag_data.size();
    eb = err_cyc.size();
    rx_data = 1'b0;
    repeat (150) @(negedge clk);
    idle(400);
    checks++;
    if (flag_data.size() != fb || err_cyc.size() != eb) begin
      failures++;
      $display("FAIL glitch_reject: flags=%0d errs=%0d, want 0/0", flag_data.size() - fb, err_cyc.size() - eb);
    end
    send_frame(8'h3C, P, 1'b1);
    idle(50);
    checks++;
    if (flag_data.size() != fb + 1 || po_data !== 8'h3C) begin
      failures++;
      $display("FAIL glitch_next_frame: flags=%0d data=%h, want 1/3C", flag_data.size() - fb, po_data);
    end else exp_last = 8'h3C;
  endtask

  task automatic test_stop_err;
    int fb, eb;
    fb = flag_data.size();
    eb = err_cyc.size();
    send_frame(8'h81, P, 1'b0);
    repeat (1500) @(negedge clk);
    checks++;
    if (err_cyc.size() != eb + 1 || flag_data.size() != fb) begin
      failures++;
      $display("FAIL stop_err_count: errs=%0d flags=%0d, want 1/0", err_cyc.size() - eb, flag_data.size() - fb);
    end
    checks++;
    if (po_data !== exp_last) begin
      failures++;
      $display("FAIL stop_err_hold: data=%h want %h", po_data, exp_last);
    end
    idle(100);
    checks++;
    if (err_cyc.size() != eb + 1 || flag_data.size() != fb) begin
      failures++;
      $display("FAIL stuck_low_release: errs=%0d flags=%0d, want 1/0", err_cyc.size() - eb, flag_data.size() - fb);
    end
  endtask

  task automatic test_reset_mid;
    int fb, eb;
    logic [9:0] bits;
    fb = flag_data.size();
    eb = err_cyc.size();
    bits = {1'b1, 8'hF0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_data = bits[i];
      if (i == 5) begin
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (P - 105) @(negedge clk);
      end else begin
        repeat (P) @(negedge clk);
      end
    end
    idle(50);
    exp_last = 8'h00;
    checks++;
    if (flag_data.size() != fb || err_cyc.size() != eb || po_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid_frame: flags=%0d errs=%0d data=%h, want 0/0/00",
               flag_data.size() - fb, err_cyc.size() - eb, po_data);
    end
    send_frame(8'h0F, P, 1'b1);
    idle(50);
    checks++;
    if (flag_data.size() != fb + 1 || po_data !== 8'h0F) begin
      failures++;
      $display("FAIL reset_next_frame: flags=%0d data=%h, want 1/0F", flag_data.size() - fb, po_data);
    end else exp_last = 8'h0F;
  endtask

  task automatic test_tolerance;
    int pers[2];
    logic [7:0] vals[2];
    int fb;
    pers[0] = 417; pers[1] = 451;
    vals[0] = 8'h00; vals[1] = 8'hFF;
    for (int p = 0; p < 2; p++) begin
      for (int v = 0; v < 2; v++) begin
        fb = flag_data.size();
        send_frame(vals[v], pers[p], 1'b1);
        idle(60);
        checks++;
        if (flag_data.size() != fb + 1 || po_data !== vals[v]) begin
          failures++;
          $display("FAIL tolerance_p%0d: flags=%0d data=%h, want 1/%h", pers[p], flag_data.size() - fb, po_data, vals[v]);
        end else exp_last = vals[v];
      end
    end
  endtask

  task automatic test_latency;
    int fb, lat;
    fb = flag_data.size();
    send_frame(8'h5A, P, 1'b1);
    idle(50);
    checks++;
    if (flag_data.size() != fb + 1) begin
      failures++;
      $display("FAIL latency_count: flags=%0d want 1", flag_data.size() - fb);
    end else begin
      exp_last = 8'h5A;
      // 3 sync/edge cycles + 9 full bit periods + 217 to the stop-bit mid-point = 4126
      lat = flag_cyc[fb] - last_fall_cyc;
      checks++;
      if (lat < 3 + 9 * P + 215 || lat > 3 + 9 * P + 219 || flag_data[fb] !== 8'h5A) begin
        failures++;
        $display("FAIL latency: got %0d cycles data=%h, want %0d+-2 data=5A", lat, flag_data[fb], 3 + 9 * P + 217);
      end
    end
  endtask

  task automatic test_random;
    int fb, eb, per;
    logic [7:0] b;
    logic bad;
    for (int n = 0; n < 6; n++) begin
      fb  = flag_data.size();
      eb  = err_cyc.size();
      per = $urandom_range(417, 451);
      b   = 8'($urandom);
      bad = ($urandom_range(0, 3) == 0);
      send_frame(b, per, ~bad);
      idle($urandom_range(20, 200));
      checks++;
      if (bad) begin
        if (err_cyc.size() != eb + 1 || flag_data.size() != fb || po_data !== exp_last) begin
          failures++;
          $display("FAIL random_bad_stop: errs=%0d flags=%0d data=%h, want 1/0/%h",
                   err_cyc.size() - eb, flag_data.size() - fb, po_data, exp_last);
        end
      end else begin
        if (flag_data.size() != fb + 1 || err_cyc.size() != eb || po_data !== b) begin
          failures++;
          $display("FAIL random_frame: per=%0d flags=%0d errs=%0d data=%h, want 1/0/%h",
                   per, flag_data.size() - fb, err_cyc.size() - eb, po_data, b);
        end
        exp_last = b;
      end
    end
  endtask

  task automatic test_strobe_rules;
    checks++;
    if (viol_excl != 0) begin
      failures++;
      $display("FAIL strobe_exclusive: %0d overlaps, want 0", viol_excl);
    end
    checks++;
    if (viol_width != 0) begin
      failures++;
      $display("FAIL strobe_width: %0d wide pulses, want 0", viol_width);
    end
    checks++;
    if (viol_stable != 0) begin
      failures++;
      $display("FAIL data_stable: %0d changes without strobe, want 0", viol_stable);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_false_start();
    test_stop_err();
    test_reset_mid();
    test_tolerance();
    test_latency();
    test_random();
    test_strobe_rules();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
